uart_tx_arbiter: RTL and testbench

//   Shares one uart_tx transmitter among N_REQ byte sources. Round-robin arbitration
//   per packet; pulses the transmitter's data-valid, tracks its active/done status,
//   and acknowledges each byte to its source. Sits between acquisition/status

---
 rtl/uart_tx_arbiter_pkg.sv | 21 ++
 rtl/uart_tx_arbiter_rr.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 153 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the uart_tx arbiter: FSM state encoding and packet header helper.
// Optional header states exist only when UART_TX_ARBITER_TAG_EN is defined.
package uart_tx_arbiter_pkg;

  typedef enum logic [2:0] {
    ARB,
    ISSUE,
    WAIT_START,
    WAIT_END
`ifdef UART_TX_ARBITER_TAG_EN
    ,
    ISSUE_HDR,
    WAIT_HDR
`endif
  } arb_state_e;

  function automatic logic [7:0] hdr_byte(input logic [3:0] prefix, input logic [3:0] id);
    return {prefix, id};
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  id,
  output logic             any_valid
);

  always_comb begin
    int idx;
    idx       = 0;
    gnt       = '0;
    id        = '0;
    any_valid = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!any_valid && req[idx]) begin
        any_valid = 1'b1;
        id        = ID_W'(idx);
        gnt[idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked sharing of one uart_tx among N_REQ byte sources.
// Define UART_TX_ARBITER_TAG_EN to prefix each packet with a {TAG_PREFIX, id} header frame.
//
// state      | meaning
// ARB        | transmitter idle check and source selection
// ISSUE      | Tx_DV/Ack pulse for a data byte is on the outputs
// WAIT_START | waiting for uart_tx to go active
// WAIT_END   | waiting for active and done both low
// ISSUE_HDR  | Tx_DV pulse for a header byte (no Ack)
// WAIT_HDR   | waiting for the header frame to go active
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter  int         N_REQ      = 4,
  parameter  logic [3:0] TAG_PREFIX = 4'hA,
  localparam int         ID_W       = $clog2(N_REQ)
) (
  input  logic               i_Clock,
  input  logic               i_Rst_n,
  input  logic [N_REQ-1:0]   i_Req_DV,
  input  logic [8*N_REQ-1:0] i_Req_Byte,
  input  logic [N_REQ-1:0]   i_Req_Last,
  output logic [N_REQ-1:0]   o_Req_Ack,
  output logic [ID_W-1:0]    o_Grant_Id,
  output logic               o_Busy,
  output logic               o_Tx_DV,
  output logic [7:0]         o_Tx_Byte,
  input  logic               i_Tx_Active,
  input  logic               i_Tx_Done
);

  arb_state_e       state, state_nxt;
  logic [N_REQ-1:0] req_elig, arb_gnt, ack_nxt, data_ack;
  logic [ID_W-1:0]  arb_id, grant_nxt, rr_ptr, rr_ptr_nxt, data_id;
  logic             arb_any, lock, lock_nxt, tx_dv_nxt, tx_idle, data_go;
  logic [7:0]       tx_byte_nxt;
`ifdef UART_TX_ARBITER_TAG_EN
  logic             hdr_pend, hdr_pend_nxt;
`endif

  assign tx_idle = !i_Tx_Active && !i_Tx_Done;

  // While a packet is open only its owner may be granted.
  always_comb begin
    req_elig = i_Req_DV;
    if (lock) req_elig = i_Req_DV & (N_REQ'(1) << o_Grant_Id);
  end

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req       (req_elig),
    .ptr       (rr_ptr),
    .gnt       (arb_gnt),
    .id        (arb_id),
    .any_valid (arb_any)
  );

  always_comb begin
    state_nxt   = state;
    tx_dv_nxt   = 1'b0;
    tx_byte_nxt = o_Tx_Byte;
    ack_nxt     = '0;
    grant_nxt   = o_Grant_Id;
    lock_nxt    = lock;
    rr_ptr_nxt  = rr_ptr;
    data_go     = 1'b0;
    data_id     = arb_id;
    data_ack    = arb_gnt;
`ifdef UART_TX_ARBITER_TAG_EN
    hdr_pend_nxt = hdr_pend;
`endif
    case (state)
      ARB: begin
        if (tx_idle && arb_any) begin
          grant_nxt = arb_id;
`ifdef UART_TX_ARBITER_TAG_EN
          if (!lock) begin
            tx_dv_nxt    = 1'b1;
            tx_byte_nxt  = hdr_byte(TAG_PREFIX, 4'(arb_id));
            hdr_pend_nxt = 1'b1;
            state_nxt    = ISSUE_HDR;
          end else begin
            data_go = 1'b1;
          end
`else
          data_go = 1'b1;
`endif
        end
      end
      ISSUE:      state_nxt = WAIT_START;
      WAIT_START: if (i_Tx_Active) state_nxt = WAIT_END;
      WAIT_END: begin
        if (tx_idle) begin
`ifdef UART_TX_ARBITER_TAG_EN
          if (hdr_pend) begin
            data_go      = 1'b1;
            data_id      = o_Grant_Id;
            data_ack     = N_REQ'(1) << o_Grant_Id;
            hdr_pend_nxt = 1'b0;
          end else begin
            state_nxt = ARB;
          end
`else
          state_nxt = ARB;
`endif
        end
      end
`ifdef UART_TX_ARBITER_TAG_EN
      ISSUE_HDR: state_nxt = WAIT_HDR;
      WAIT_HDR:  if (i_Tx_Active) state_nxt = WAIT_END;
`endif
      default:   state_nxt = ARB;
    endcase

    if (data_go) begin
      tx_dv_nxt   = 1'b1;
      tx_byte_nxt = i_Req_Byte[8*data_id +: 8];
      ack_nxt     = data_ack;
      lock_nxt    = !i_Req_Last[data_id];
      if (i_Req_Last[data_id])
        rr_ptr_nxt = (data_id == ID_W'(N_REQ - 1)) ? '0 : data_id + 1'b1;
      state_nxt   = ISSUE;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state      <= ARB;
      o_Tx_DV    <= 1'b0;
      o_Tx_Byte  <= 8'h00;
      o_Req_Ack  <= '0;
      o_Grant_Id <= '0;
      o_Busy     <= 1'b0;
      lock       <= 1'b0;
      rr_ptr     <= '0;
`ifdef UART_TX_ARBITER_TAG_EN
      hdr_pend   <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      o_Tx_DV    <= tx_dv_nxt;
      o_Tx_Byte  <= tx_byte_nxt;
      o_Req_Ack  <= ack_nxt;
      o_Grant_Id <= grant_nxt;
      o_Busy     <= (state_nxt != ARB);
      lock       <= lock_nxt;
      rr_ptr     <= rr_ptr_nxt;
`ifdef UART_TX_ARBITER_TAG_EN
      hdr_pend   <= hdr_pend_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural uart_tx (4 clocks/bit), line decoder, frame/ack scoreboards.
module tb_uart_tx_arbiter;
  localparam int N_REQ = 4;

  logic               clk      = 1'b0;
  logic               rst_n    = 1'b0;
  logic [N_REQ-1:0]   req_dv   = '0;
  logic [N_REQ-1:0]   req_last = '0;
  logic [8*N_REQ-1:0] req_byte = '0;
  logic [N_REQ-1:0]   req_ack;
  logic [1:0]         grant_id;
  logic               busy, tx_dv;
  logic [7:0]         tx_byte;

  logic       tx_act  = 1'b0;
  logic       tx_done = 1'b0;
  logic       tx_line = 1'b1;
  logic [9:0] tx_shift = '1;
  int         tx_cnt = 0, tx_bit = 0, done_cnt = 0;

  int n_cmp = 0, n_err = 0;
  int n_dv = 0, exp_dv = 0, n_extra_frames = 0, n_extra_acks = 0;
  int ack_id;
  logic [7:0] rx_byte;
  logic [7:0] exp_frames[$];
  int         exp_acks[$];
  logic [8:0] src_q[N_REQ][$];
  bit         pkt_open[N_REQ];

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N_REQ), .TAG_PREFIX(4'hA)) dut (
    .i_Clock     (clk),
    .i_Rst_n     (rst_n),
    .i_Req_DV    (req_dv),
    .i_Req_Byte  (req_byte),
    .i_Req_Last  (req_last),
    .o_Req_Ack   (req_ack),
    .o_Grant_Id  (grant_id),
    .o_Busy      (busy),
    .o_Tx_DV     (tx_dv),
    .o_Tx_Byte   (tx_byte),
    .i_Tx_Active (tx_act),
    .i_Tx_Done   (tx_done)
  );

  // uart_tx stand-in: never reset by the DUT reset, done held two cycles after stop bit
  always @(posedge clk) begin
    if (done_cnt > 0) begin
      done_cnt <= done_cnt - 1;
      if (done_cnt == 1) tx_done <= 1'b0;
    end
    if (!tx_act) begin
      if (tx_dv && done_cnt == 0) begin
        tx_act   <= 1'b1;
        tx_shift <= {1'b1, tx_byte, 1'b0};
        tx_bit   <= 0;
        tx_cnt   <= 0;
        tx_line  <= 1'b0;
      end
    end else if (tx_cnt == 3) begin
      tx_cnt <= 0;
      if (tx_bit == 9) begin
        tx_act   <= 1'b0;
        tx_line  <= 1'b1;
        tx_done  <= 1'b1;
        done_cnt <= 2;
      end else begin
        tx_bit  <= tx_bit + 1;
        tx_line <= tx_shift[tx_bit+1];
      end
    end else begin
      tx_cnt <= tx_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic send(input int k, input logic [7:0] b, input logic last);
`ifdef UART_TX_ARBITER_TAG_EN
    if (!pkt_open[k]) begin
      exp_frames.push_back({4'hA, 4'(k)});
      exp_dv++;
    end
    pkt_open[k] = !last;
`endif
    exp_frames.push_back(b);
    exp_acks.push_back(k);
    exp_dv++;
    src_q[k].push_back({last, b});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_ack",   32'(req_ack),  32'd0);
    chk("rst_dv",    32'(tx_dv),    32'd0);
    chk("rst_byte",  32'(tx_byte),  32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_busy",  32'(busy),     32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_frames.size() > 0 || exp_acks.size() > 0 || tx_act || tx_done) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < 3000), 32'd1);
  endtask

  // source drivers: hold byte until its Ack, then present the next queued one
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < N_REQ; k++) begin
      if (req_dv[k] && req_ack[k]) begin
        void'(src_q[k].pop_front());
        req_dv[k] = 1'b0;
      end
      if (!req_dv[k] && src_q[k].size() > 0) begin
        {req_last[k], req_byte[k*8 +: 8]} = src_q[k][0];
        req_dv[k] = 1'b1;
      end
    end
  end

  // output monitor: Tx_DV only into an idle transmitter, Acks one-hot, in order, with Tx_DV
  initial forever begin
    @(negedge clk);
    if (tx_dv) begin
      n_dv++;
      chk("dv_while_busy", 32'({tx_act, tx_done}), 32'd0);
    end
    if (|req_ack) begin
      ack_id = 0;
      for (int k = 0; k < N_REQ; k++) if (req_ack[k]) ack_id = k;
      chk("ack_onehot", 32'($countones(req_ack)), 32'd1);
      chk("ack_with_dv", 32'(tx_dv), 32'd1);
      chk("ack_grant_id", 32'(grant_id), 32'(ack_id));
      if (exp_acks.size() > 0) chk("ack_order", 32'(ack_id), 32'(exp_acks.pop_front()));
      else n_extra_acks++;
    end
  end

  // serial line decoder, samples mid-bit
  initial forever begin
    @(negedge tx_line);
    repeat (2) @(posedge clk);
    for (int b = 0; b < 8; b++) begin
      repeat (4) @(posedge clk);
      rx_byte[b] = tx_line;
    end
    repeat (4) @(posedge clk);
    chk("stop_bit", 32'(tx_line), 32'd1);
    if (exp_frames.size() > 0) chk("frame", 32'(rx_byte), 32'(exp_frames.pop_front()));
    else n_extra_frames++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    do_reset();

    // single byte: latency, pulse width, busy release
    send(0, 8'h55, 1'b1);
    wait (req_dv[0]);
    @(negedge clk);
    chk("t1_dv_latency", 32'(tx_dv), 32'd1);
`ifdef UART_TX_ARBITER_TAG_EN
    chk("t1_byte", 32'(tx_byte), 32'h0A0);
    chk("t1_ack",  32'(req_ack), 32'd0);
`else
    chk("t1_byte", 32'(tx_byte), 32'h055);
    chk("t1_ack",  32'(req_ack), 32'd1);
`endif
    @(negedge clk);
    chk("t1_dv_pulse", 32'(tx_dv), 32'd0);
    chk("t1_busy_hi",  32'(busy),  32'd1);
    wait_drain("t1_drain");
    repeat (2) @(negedge clk);
    chk("t1_busy_low", 32'(busy), 32'd0);

    // all four at once from a fresh pointer, then wrap to 0 before 3
    do_reset();
    for (int k = 0; k < N_REQ; k++) send(k, 8'h10 + 8'(k), 1'b1);
    wait_drain("t2_drain_a");
    send(0, 8'h20, 1'b1);
    send(3, 8'h23, 1'b1);
    wait_drain("t2_drain_b");
    chk("t2_last_grant", 32'(grant_id), 32'd3);

    // locked packet from 1 while 2 waits
    send(1, 8'hA1, 1'b0);
    send(1, 8'hA2, 1'b0);
    send(1, 8'hA3, 1'b1);
    send(2, 8'h22, 1'b1);
    wait_drain("t3_drain");

    // reset mid-frame with the transmitter still running
    send(0, 8'h5A, 1'b1);
    n = 0;
    while (!tx_act && n < 200) begin @(negedge clk); n++; end
    chk("t4_frame_start", 32'(tx_act), 32'd1);
    repeat (12) @(negedge clk);
    do_reset();
    send(2, 8'hC3, 1'b1);
    n = 0;
    while (!tx_dv && n < 300) begin @(negedge clk); n++; end
    chk("t4_dv_seen", 32'(tx_dv), 32'd1);
    chk("t4_dv_idle", 32'({tx_act, tx_done}), 32'd0);
    wait_drain("t4_drain");

`ifdef UART_TX_ARBITER_TAG_EN
    send(3, 8'h7E, 1'b1);
    wait_drain("t5_drain_a");
    send(3, 8'hB0, 1'b0);
    send(3, 8'hB1, 1'b1);
    wait_drain("t5_drain_b");
`endif

    repeat (20) @(negedge clk);
    chk("dv_count",     32'(n_dv), 32'(exp_dv));
    chk("extra_frames", 32'(n_extra_frames), 32'd0);
    chk("extra_acks",   32'(n_extra_acks), 32'd0);
    chk("frames_left",  32'(exp_frames.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
